// File: rtl/phase_to_sample.sv
// Audio-rate sampler: captures the accumulated phase every SAMPLE_DIV cycles and
// emits a sine/square/saw/triangle sample on a valid/ready stream. SAMPLE_ATTEN_EN adds a shift stage.
module phase_to_sample #(
    parameter int unsigned SAMPLE_DIV    = 2268,
    parameter int unsigned LUT_ADDR_BITS = 8,
    parameter int unsigned SAMPLE_WIDTH  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [31:0]             phase_in,
    input  logic [1:0]              wave_sel_in,
`ifdef SAMPLE_ATTEN_EN
    input  logic [3:0]              atten_in,
`endif
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    sample_valid_out,
    input  logic                    sample_ready_in,
    output logic                    overrun_out
);

    localparam int unsigned CntW     = $clog2(SAMPLE_DIV);
    localparam int unsigned LutDepth = 1 << LUT_ADDR_BITS;
    localparam int unsigned MagW     = SAMPLE_WIDTH - 1;

    // Quarter-wave table, evaluated at elaboration; entries sit at half-step offsets.
    function automatic int rom_entry(input int i);
        real x;
        x = 32767.0 * $sin((real'(i) + 0.5) * 3.141592653589793 / real'(2 * LutDepth));
        return $rtoi(x + 0.5);
    endfunction

    logic [MagW-1:0] w_rom [LutDepth];
    for (genvar gi = 0; gi < LutDepth; gi++) begin : g_rom
        assign w_rom[gi] = MagW'(rom_entry(gi));
    end

    logic [CntW-1:0]          r_cnt;
    logic                     w_tick;
    logic                     r_v0, r_v1;
    logic [31:15]             r_ph0, r_ph1;
    logic [1:0]               r_sel0, r_sel1;
    logic [LUT_ADDR_BITS-1:0] w_addr;
    logic [MagW-1:0]          r_rom1;
    logic [SAMPLE_WIDTH-1:0]  w_mag, w_tri, w_s2;
    logic [SAMPLE_WIDTH-1:0]  w_load_val;
    logic                     w_load_v;
    logic [SAMPLE_WIDTH-1:0]  r_sample;
    logic                     r_valid, r_ovr;
    logic                     w_unused_phase;

    assign w_unused_phase = ^phase_in[14:0];
    assign w_tick = (r_cnt == CntW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
            r_v0  <= 1'b0;
            r_v1  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CntW'(1);
            r_v0  <= w_tick;
            r_v1  <= r_v0;
        end
    end

    // Odd quadrants walk the table backwards.
    assign w_addr = r_ph0[30] ? ~r_ph0[29 -: LUT_ADDR_BITS] : r_ph0[29 -: LUT_ADDR_BITS];

`ifdef SAMPLE_ATTEN_EN
    logic [3:0]              r_atten0, r_atten1;
    logic [SAMPLE_WIDTH-1:0] r_s3;
    logic                    r_v3;
`endif

    always_ff @(posedge clk_in) begin
        if (w_tick) begin
            r_ph0  <= phase_in[31:15];
            r_sel0 <= wave_sel_in;
`ifdef SAMPLE_ATTEN_EN
            r_atten0 <= atten_in;
`endif
        end
        r_rom1 <= w_rom[w_addr];
        r_ph1  <= r_ph0;
        r_sel1 <= r_sel0;
`ifdef SAMPLE_ATTEN_EN
        r_atten1 <= r_atten0;
`endif
    end

    assign w_mag = {1'b0, r_rom1};
    assign w_tri = r_ph1[30:15] ^ 16'h8000;

    always_comb begin
        w_s2 = '0;
        case (r_sel1)
            2'd0:    w_s2 = r_ph1[31] ? (16'd0 - w_mag) : w_mag;
            2'd1:    w_s2 = r_ph1[31] ? 16'h8001 : 16'h7fff;
            2'd2:    w_s2 = r_ph1[31:16] ^ 16'h8000;
            default: w_s2 = r_ph1[31] ? ~w_tri : w_tri;
        endcase
    end

`ifdef SAMPLE_ATTEN_EN
    always_ff @(posedge clk_in) begin
        r_s3 <= $signed(w_s2) >>> r_atten1;
        if (!rst_in) begin
            r_v3 <= 1'b0;
        end else begin
            r_v3 <= r_v1;
        end
    end

    assign w_load_v   = r_v3;
    assign w_load_val = r_s3;
`else
    assign w_load_v   = r_v1;
    assign w_load_val = w_s2;
`endif

    // A new sample replaces the held one only if it is gone or leaving this cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (w_load_v) begin
            if (!r_valid || sample_ready_in) begin
                r_sample <= w_load_val;
                r_valid  <= 1'b1;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (sample_ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign overrun_out      = r_ovr;

endmodule
